// File: rtl/mpy_accumulator.sv
// ---------------------------------------------------------------------------
// mpy_accumulator
//   Sums a frame of unsigned products from the MBE multiplier into a wide
//   accumulator. A frame ends when a product with LAST_I is accepted, or when
//   MAX_LEN terms have been accepted. The result is then held behind a
//   valid/ready handshake until the consumer takes it.
//
// Ports
//   CLK         in   1       clock, rising edge
//   RST_n       in   1       asynchronous active-low reset
//   CLR_I       in   1       synchronous abort/clear, beats every other input
//   PROD_I      in   PROD_W  unsigned product
//   PROD_VLD_I  in   1       PROD_I valid
//   LAST_I      in   1       PROD_I is the last term of the frame
//   PROD_RDY_O  out  1       stage can accept a product (state register only)
//   ACC_O       out  ACC_W   accumulated sum
//   CNT_O       out  CNT_W   number of terms in ACC_O
//   OVF_O       out  1       sticky carry out of ACC_W within the frame
//   ACC_VLD_O   out  1       result valid
//   ACC_RDY_I   in   1       consumer accepts the result
// ---------------------------------------------------------------------------
module mpy_accumulator #(
  parameter  int PROD_W  = 64,
  parameter  int ACC_W   = 72,
  parameter  int MAX_LEN = 256,
  localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              CLR_I,
  input  logic [PROD_W-1:0] PROD_I,
  input  logic              PROD_VLD_I,
  input  logic              LAST_I,
  output logic              PROD_RDY_O,
  output logic [ACC_W-1:0]  ACC_O,
  output logic [CNT_W-1:0]  CNT_O,
  output logic              OVF_O,
  output logic              ACC_VLD_O,
  input  logic              ACC_RDY_I
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_acc_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              r_ovf;
  logic              w_ovf_next;

  logic              w_accept;
  logic [ACC_W-1:0]  w_prod_ext;
  logic [ACC_W:0]    w_sum;      // one extra bit to capture the carry out
  logic [CNT_W-1:0]  w_cnt_inc;

  // Ready depends on the state register alone, so there is no combinational
  // path from any input to PROD_RDY_O.
  assign PROD_RDY_O = (r_state != S_HOLD);
  assign ACC_VLD_O  = (r_state == S_HOLD);
  assign ACC_O      = r_acc;
  assign CNT_O      = r_cnt;
  assign OVF_O      = r_ovf;

  assign w_accept   = PROD_VLD_I & PROD_RDY_O;
  assign w_prod_ext = ACC_W'(PROD_I);
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_cnt_inc  = r_cnt + 1'b1;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_ovf   <= w_ovf_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_ovf_next   = r_ovf;

    if (CLR_I) begin
      // Abort: any product presented this cycle is dropped.
      w_state_next = S_IDLE;
      w_acc_next   = '0;
      w_cnt_next   = '0;
      w_ovf_next   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // The previous result stays visible until the first term of the
          // next frame replaces it.
          if (w_accept) begin
            w_acc_next   = w_prod_ext;
            w_cnt_next   = CNT_W'(1);
            w_ovf_next   = 1'b0;
            w_state_next = (LAST_I || (MAX_LEN == 1)) ? S_HOLD : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            w_acc_next   = w_sum[ACC_W-1:0];
            w_cnt_next   = w_cnt_inc;
            w_ovf_next   = r_ovf | w_sum[ACC_W];
            w_state_next = (LAST_I || (w_cnt_inc == CNT_W'(MAX_LEN))) ? S_HOLD : S_ACCUM;
          end
        end
        S_HOLD: begin
          if (ACC_RDY_I) begin
            w_state_next = S_IDLE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpy_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mpy_accumulator
//   Two instances share one stimulus stream: a 72-bit accumulator and a
//   64-bit accumulator (for carry-out behaviour). A reference model builds the
//   expected result of every frame when its terms are driven and pushes it to
//   a scoreboard; a monitor pops and compares on every result handshake.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mpy_accumulator;

  localparam int PROD_W  = 64;
  localparam int MAX_LEN = 256;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  logic              CLK = 1'b0;
  logic              RST_n;
  logic              CLR_I;
  logic [PROD_W-1:0] PROD_I;
  logic              PROD_VLD_I;
  logic              LAST_I;
  logic              ACC_RDY_I;

  logic              rdy72, vld72, ovf72;
  logic [71:0]       acc72;
  logic [CNT_W-1:0]  cnt72;
  logic              rdy64, vld64, ovf64;
  logic [63:0]       acc64;
  logic [CNT_W-1:0]  cnt64;

  always #5 CLK = ~CLK;

  mpy_accumulator #(.PROD_W(PROD_W), .ACC_W(72), .MAX_LEN(MAX_LEN)) u_dut72 (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .CLR_I      (CLR_I),
    .PROD_I     (PROD_I),
    .PROD_VLD_I (PROD_VLD_I),
    .LAST_I     (LAST_I),
    .PROD_RDY_O (rdy72),
    .ACC_O      (acc72),
    .CNT_O      (cnt72),
    .OVF_O      (ovf72),
    .ACC_VLD_O  (vld72),
    .ACC_RDY_I  (ACC_RDY_I)
  );

  mpy_accumulator #(.PROD_W(PROD_W), .ACC_W(64), .MAX_LEN(MAX_LEN)) u_dut64 (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .CLR_I      (CLR_I),
    .PROD_I     (PROD_I),
    .PROD_VLD_I (PROD_VLD_I),
    .LAST_I     (LAST_I),
    .PROD_RDY_O (rdy64),
    .ACC_O      (acc64),
    .CNT_O      (cnt64),
    .OVF_O      (ovf64),
    .ACC_VLD_O  (vld64),
    .ACC_RDY_I  (ACC_RDY_I)
  );

  typedef struct {
    logic [71:0] acc72;
    logic        ovf72;
    logic [63:0] acc64;
    logic        ovf64;
    int          cnt;
  } sb_t;

  sb_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state for the frame in progress
  logic [71:0] mdl_acc72;
  logic        mdl_ovf72;
  logic [63:0] mdl_acc64;
  logic        mdl_ovf64;
  int          mdl_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Model one accepted term; push the expected result when the frame ends.
  task automatic mdl_term(input logic [63:0] v, input logic last);
    logic [72:0] s72;
    logic [64:0] s64;
    if (mdl_cnt == 0) begin
      mdl_acc72 = {8'd0, v};
      mdl_acc64 = v;
      mdl_ovf72 = 1'b0;
      mdl_ovf64 = 1'b0;
    end else begin
      s72 = {1'b0, mdl_acc72} + {9'd0, v};
      s64 = {1'b0, mdl_acc64} + {1'b0, v};
      mdl_acc72 = s72[71:0];
      mdl_acc64 = s64[63:0];
      mdl_ovf72 = mdl_ovf72 | s72[72];
      mdl_ovf64 = mdl_ovf64 | s64[64];
    end
    mdl_cnt++;
    if (last || mdl_cnt == MAX_LEN) begin
      sb_q.push_back('{acc72: mdl_acc72, ovf72: mdl_ovf72,
                       acc64: mdl_acc64, ovf64: mdl_ovf64, cnt: mdl_cnt});
      mdl_cnt = 0;
    end
  endtask

  // Called just after a rising edge (+1). Presents a term, waits for ready,
  // and returns one time unit after the edge that accepted it.
  task automatic send_term(input logic [63:0] v, input logic last);
    int guard = 0;
    PROD_I     = v;
    PROD_VLD_I = 1'b1;
    LAST_I     = last;
    while (!rdy72 && guard < 200) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (guard >= 200) chk("rdy_timeout", 128'(guard), 128'd0);
    mdl_term(v, last);
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs();
    PROD_VLD_I = 1'b0;
    LAST_I     = 1'b0;
    PROD_I     = '0;
  endtask

  // Result monitor: inputs change just after rising edges, so the falling
  // edge sees stable handshake signals for the edge that follows.
  always @(negedge CLK) begin
    if (RST_n && !CLR_I && vld72 && ACC_RDY_I) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_result", 128'(sb_q.size()), 128'd1);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("sb_acc72", 128'(acc72), 128'(e.acc72));
        chk("sb_cnt72", 128'(cnt72), 128'(e.cnt));
        chk("sb_ovf72", 128'(ovf72), 128'(e.ovf72));
        chk("sb_vld64", 128'(vld64), 128'd1);
        chk("sb_acc64", 128'(acc64), 128'(e.acc64));
        chk("sb_ovf64", 128'(ovf64), 128'(e.ovf64));
      end
    end
  end

  initial begin
    logic [63:0] big;
    int          guard;
    big = 64'hFFFF_FFFE_0000_0001;

    RST_n     = 1'b0;
    CLR_I     = 1'b0;
    ACC_RDY_I = 1'b1;
    idle_inputs();
    #2;
    chk("rst_acc",  128'(acc72), 128'd0);
    chk("rst_cnt",  128'(cnt72), 128'd0);
    chk("rst_vld",  128'(vld72), 128'd0);
    chk("rst_rdy",  128'(rdy72), 128'd1);
    @(posedge CLK); #1;
    RST_n = 1'b1;
    @(posedge CLK); #1;

    // T1: asynchronous reset in the middle of a frame (CNT=5)
    for (int i = 1; i <= 5; i++) send_term(64'(i), 1'b0);
    idle_inputs();
    chk("t1_cnt_before", 128'(cnt72), 128'd5);
    #2;
    RST_n = 1'b0;
    #1;
    chk("t1_acc", 128'(acc72), 128'd0);
    chk("t1_cnt", 128'(cnt72), 128'd0);
    chk("t1_ovf", 128'(ovf72), 128'd0);
    chk("t1_vld", 128'(vld72), 128'd0);
    chk("t1_rdy", 128'(rdy72), 128'd1);
    mdl_cnt = 0;
    @(posedge CLK); #1;
    RST_n = 1'b1;
    @(posedge CLK); #1;

    // T2: frame {3,5,7,11}, with a bubble carrying a stray LAST_I
    ACC_RDY_I = 1'b1;
    send_term(64'd3, 1'b0);
    send_term(64'd5, 1'b0);
    PROD_VLD_I = 1'b0;
    LAST_I     = 1'b1;
    PROD_I     = 64'd1000;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("t2_bubble_cnt", 128'(cnt72), 128'd2);
    chk("t2_bubble_vld", 128'(vld72), 128'd0);
    send_term(64'd7, 1'b0);
    send_term(64'd11, 1'b1);
    idle_inputs();
    chk("t2_vld_latency", 128'(vld72), 128'd1);
    chk("t2_acc", 128'(acc72), 128'd26);
    chk("t2_cnt", 128'(cnt72), 128'd4);
    chk("t2_ovf", 128'(ovf72), 128'd0);
    @(posedge CLK); #1;
    chk("t2_vld_drop", 128'(vld72), 128'd0);
    chk("t2_acc_kept", 128'(acc72), 128'd26);

    // T3: backpressure for 5 cycles while a product waits on PROD_I
    ACC_RDY_I = 1'b0;
    send_term(64'd3, 1'b0);
    send_term(64'd5, 1'b0);
    send_term(64'd7, 1'b0);
    send_term(64'd11, 1'b1);
    PROD_I     = 64'd99;
    PROD_VLD_I = 1'b1;
    LAST_I     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_rdy_c%0d", i), 128'(rdy72), 128'd0);
      chk($sformatf("t3_acc_c%0d", i), 128'(acc72), 128'd26);
      chk($sformatf("t3_cnt_c%0d", i), 128'(cnt72), 128'd4);
      @(posedge CLK); #1;
    end
    ACC_RDY_I = 1'b1;
    send_term(64'd99, 1'b1);
    idle_inputs();
    chk("t3_held_prod_acc", 128'(acc72), 128'd99);
    chk("t3_held_prod_cnt", 128'(cnt72), 128'd1);
    @(posedge CLK); #1;

    // T4: 256 maximal products, no LAST -> frame closes at MAX_LEN
    for (int i = 0; i < MAX_LEN; i++) send_term(big, 1'b0);
    idle_inputs();
    chk("t4_vld", 128'(vld72), 128'd1);
    chk("t4_cnt", 128'(cnt72), 128'd256);
    chk("t4_acc", 128'(acc72), 128'd256 * 128'hFFFF_FFFE_0000_0001);
    chk("t4_ovf", 128'(ovf72), 128'd0);
    @(posedge CLK); #1;

    // T5: carry out of a 64-bit accumulator, then cleared by the next frame
    send_term(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_term(64'd2, 1'b1);
    idle_inputs();
    chk("t5_acc64", 128'(acc64), 128'd1);
    chk("t5_ovf64", 128'(ovf64), 128'd1);
    @(posedge CLK); #1;
    chk("t5_ovf64_kept", 128'(ovf64), 128'd1);
    send_term(64'd4, 1'b1);
    idle_inputs();
    chk("t5_next_acc64", 128'(acc64), 128'd4);
    chk("t5_next_ovf64", 128'(ovf64), 128'd0);
    @(posedge CLK); #1;

    // T6: CLR_I with a valid product at term 3
    send_term(64'd1, 1'b0);
    send_term(64'd2, 1'b0);
    PROD_I     = 64'd5;
    PROD_VLD_I = 1'b1;
    LAST_I     = 1'b1;
    CLR_I      = 1'b1;
    @(posedge CLK); #1;
    CLR_I = 1'b0;
    idle_inputs();
    mdl_cnt = 0;
    chk("t6_acc", 128'(acc72), 128'd0);
    chk("t6_cnt", 128'(cnt72), 128'd0);
    chk("t6_ovf", 128'(ovf72), 128'd0);
    chk("t6_vld", 128'(vld72), 128'd0);
    chk("t6_rdy", 128'(rdy72), 128'd1);
    send_term(64'd9, 1'b1);
    idle_inputs();
    chk("t6_next_acc", 128'(acc72), 128'd9);
    chk("t6_next_cnt", 128'(cnt72), 128'd1);

    guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      @(posedge CLK); #1;
      guard++;
    end
    chk("sb_drain", 128'(sb_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
